regfile_mp: RTL
===============

Name: regfile_mp

Overview:
Parametrised multi-port general-purpose register file for the MIPS core. It supersedes the fixed 2-read/1-write file. It adds configurable width, depth and port counts, a hardwired zero register, and a per-register pending-write scoreboard. IDU reads operands and reserves destinations through it. WBU (and the future second writeback lane) retires writes through it.

Parameters:
DATA_W, 32, register width in bits
ADDR_W, 5, address width; depth = 2**ADDR_W
NUM_RD, 2, number of read ports (>=1)
NUM_WR, 2, number of write ports (>=1)
ZERO_REG, 1, 1 = register 0 reads 0, ignores writes and reservations

Ports:
clk  input  1  clock, rising edge
rst  input  1  asynchronous, active-high reset
rd_en  input  NUM_RD  per-port read enable
rd_addr  input  NUM_RD*ADDR_W  read addresses, port k at [k*ADDR_W +: ADDR_W]
rd_data  output  NUM_RD*DATA_W  read data, port k at [k*DATA_W +: DATA_W]
rd_busy  output  NUM_RD  1 = addressed register has a pending write
rsv_en  input  1  reserve destination (IDU issue)
rsv_addr  input  ADDR_W  destination being reserved
wr_en  input  NUM_WR  per-port write enable
wr_addr  input  NUM_WR*ADDR_W  write addresses
wr_data  input  NUM_WR*DATA_W  write data
flush  input  1  synchronous clear of all pending bits (pipeline flush)
busy_cnt  output  ADDR_W+1  number of registers currently pending

Behaviour:
- Reset (rst=1, async): all registers = 0, all pending bits = 0, busy_cnt = 0. rd_data = 0 while rst is held; rd_busy = 0.
- Read: combinational, zero latency. rd_en[k]=0 -> rd_data[k]=0 and rd_busy[k]=0.
- Read of addr 0 with ZERO_REG=1: data 0, busy 0.
- Write: on posedge clk, each enabled port writes its address. Blocking-assignment ordering is not used; the result is defined by priority only.
- Write conflict: two ports to the same address in one cycle -> highest-index port wins.
- Address 0 writes are dropped when ZERO_REG=1. With ZERO_REG=0, register 0 is ordinary storage.
- Scoreboard: one pending bit per register, all updated on posedge clk in priority order (highest first):
  - flush=1 -> all bits cleared. A simultaneous rsv is ignored. Writes still commit data.
  - rsv_en=1 -> pending[rsv_addr] set. This takes priority over a same-cycle write clear to the same address, because the new producer owns the register.
  - wr_en[j]=1 -> pending[wr_addr[j]] cleared.
- Writes to a non-pending register are legal: data commits and the pending bit stays 0.
- rsv_addr=0 with ZERO_REG=1 is ignored.
- busy_cnt: registered population count of the pending bits, updated the same edge as the bits. It never exceeds 2**ADDR_W (or 2**ADDR_W-1 when ZERO_REG=1), with no wrap.
- Reset mid-operation: rst dominates clk. All state clears immediately, including in-flight writes of that cycle.
- rd_busy reflects the registered pending bits unless the bypass below is compiled in.

Optional Feature:
REGFILE_WRITE_BYPASS_EN
- Defined: a read whose address matches an enabled write port in the same cycle returns that wr_data. With multiple matches, the highest index wins. The zero-register rule still applies.
  - rd_busy is 0 for that read if the register is being cleared this cycle.
  - rd_busy is 1 if a same-cycle rsv_en to the same address re-reserves it.
  - This removes the one-cycle WB->ID bubble.
- Undefined: reads return stored contents only. New data is visible the cycle after the write edge, and rd_busy follows the registered bits.

Test Plan:
- Reset -> all rd_data=0, rd_busy=0, busy_cnt=0. Write r5=0xDEADBEEF on port 0, next cycle read r5 port 1 -> 0xDEADBEEF.
- ZERO_REG: write r0=0x12345678, rsv r0 -> read r0 = 0, rd_busy=0, busy_cnt unchanged.
- Write conflict: port0 r7=0x1111, port1 r7=0x2222 same edge -> r7 reads 0x2222.
- Scoreboard: rsv r3 -> busy_cnt=1, rd_busy=1. Same-cycle rsv r3 + wr r3=0xA5 -> still pending, data 0xA5. Next wr r3 -> busy 0, busy_cnt=0.
- Flush: reserve r1,r2,r4 -> busy_cnt=3. flush with rsv r9 -> busy_cnt=0, r9 not pending.
- Bypass: r8=0x0 stored, same cycle wr r8=0xCAFE and read r8 -> 0xCAFE with REGFILE_WRITE_BYPASS_EN, 0x0 without. Assert rst mid-write -> r8 reads 0.

Source files
------------

// File: rtl/regfile_mp.sv
// Multi-port register file with optional hardwired zero register and per-register pending-write scoreboard.
// Optional same-cycle write-to-read bypass: define REGFILE_WRITE_BYPASS_EN.
module regfile_mp #(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 5,
    parameter int NUM_RD   = 2,
    parameter int NUM_WR   = 2,
    parameter int ZERO_REG = 1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NUM_RD-1:0]        rd_en,
    input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
    output logic [NUM_RD*DATA_W-1:0] rd_data,
    output logic [NUM_RD-1:0]        rd_busy,
    input  logic                     rsv_en,
    input  logic [ADDR_W-1:0]        rsv_addr,
    input  logic [NUM_WR-1:0]        wr_en,
    input  logic [NUM_WR*ADDR_W-1:0] wr_addr,
    input  logic [NUM_WR*DATA_W-1:0] wr_data,
    input  logic                     flush,
    output logic [ADDR_W:0]          busy_cnt
);
    localparam int DEPTH = 1 << ADDR_W;

    logic [DATA_W-1:0] regs [DEPTH];
    logic [DEPTH-1:0]  pend;
    logic [DEPTH-1:0]  pend_nxt;
    logic [ADDR_W:0]   cnt_nxt;

    function automatic logic is_zero(input logic [ADDR_W-1:0] a);
        return (ZERO_REG != 0) && (a == '0);
    endfunction

    // Lowest priority first so later assignments override: write clear, reserve, flush.
    always_comb begin
        pend_nxt = pend;
        for (int j = 0; j < NUM_WR; j++) begin
            if (wr_en[j]) pend_nxt[wr_addr[j*ADDR_W +: ADDR_W]] = 1'b0;
        end
        if (rsv_en && !is_zero(rsv_addr)) pend_nxt[rsv_addr] = 1'b1;
        if (flush) pend_nxt = '0;
        if (ZERO_REG != 0) pend_nxt[0] = 1'b0;
    end

    always_comb begin
        cnt_nxt = '0;
        for (int i = 0; i < DEPTH; i++) begin
            cnt_nxt = cnt_nxt + {{ADDR_W{1'b0}}, pend_nxt[i]};
        end
    end

    // Non-blocking writes in ascending port order: the highest enabled port wins a conflict.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) regs[i] <= '0;
            pend     <= '0;
            busy_cnt <= '0;
        end else begin
            for (int j = 0; j < NUM_WR; j++) begin
                if (wr_en[j] && !is_zero(wr_addr[j*ADDR_W +: ADDR_W]))
                    regs[wr_addr[j*ADDR_W +: ADDR_W]] <= wr_data[j*DATA_W +: DATA_W];
            end
            pend     <= pend_nxt;
            busy_cnt <= cnt_nxt;
        end
    end

    for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
        logic [ADDR_W-1:0] ra;
        logic [DATA_W-1:0] rv;
        logic              rb;

        assign ra = rd_addr[k*ADDR_W +: ADDR_W];

        always_comb begin
            rv = regs[ra];
            rb = pend[ra];
`ifdef REGFILE_WRITE_BYPASS_EN
            for (int j = 0; j < NUM_WR; j++) begin
                if (wr_en[j] && (wr_addr[j*ADDR_W +: ADDR_W] == ra)) begin
                    rv = wr_data[j*DATA_W +: DATA_W];
                    rb = pend_nxt[ra];
                end
            end
`endif
            if (rst || !rd_en[k] || is_zero(ra)) begin
                rv = '0;
                rb = 1'b0;
            end
        end

        assign rd_data[k*DATA_W +: DATA_W] = rv;
        assign rd_busy[k]                  = rb;
    end

endmodule
